// File: rtl/tetris_feed_ctrl.sv
// tetris_feed_ctrl: buffers (tetromino, position) requests and feeds the TETRIS core one piece per round; optional watchdog under TETRIS_FEED_TIMEOUT_EN.
// Latency: push into an empty FIFO while IDLE -> core_in_valid_o 3 cycles later; game_done_o is high during the single DONE cycle.
// Backpressure: req_ready_o low when FIFO full or game quota reached (IDLE/ISSUE/WAIT), quota-only in DRAIN (pushes dropped), always low in DONE.
module tetris_feed_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ROUNDS = 16
`ifdef TETRIS_FEED_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [2:0] req_tetromino_i,
  input  logic [2:0] req_position_i,
  output logic       core_in_valid_o,
  output logic [2:0] core_tetrominoes_o,
  output logic [2:0] core_position_o,
  input  logic       core_score_valid_i,
  input  logic       core_fail_i,
  input  logic [3:0] core_score_i,
  output logic       game_done_o,
  output logic       game_fail_o,
  output logic [3:0] final_score_o,
  output logic [3:0] round_cnt_o,
  output logic       proto_err_o,
  output logic       busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [4:0]    ROUNDS_C = 5'(ROUNDS);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    round_cnt_q, round_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cin_vld_q, cin_vld_d;
  logic [2:0]    tet_q, tet_d, pos_q, pos_d;
  logic          game_fail_q, game_fail_d;
  logic [3:0]    final_score_q, final_score_d;
  logic          proto_err_q, proto_err_d;
  logic [5:0]    mem_q [DEPTH];

  logic          full, empty, acc_room, push, wr_en, pop, flush;

`ifdef TETRIS_FEED_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
  logic [9:0] wait_cnt_q, wait_cnt_d;

  // Watchdog counts WAIT cycles; it is zero whenever WAIT is (re)entered.
  always_comb begin
    wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 10'd1 : 10'd0;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Upstream handshake: quota caps pushes per game so games never mix.
  always_comb begin
    full     = (cnt_q == DEPTH_C);
    empty    = (cnt_q == '0);
    acc_room = (acc_cnt_q < ROUNDS_C);
    case (state_q)
      S_DRAIN: req_ready_o = acc_room;
      S_DONE:  req_ready_o = 1'b0;
      default: req_ready_o = !full && acc_room;
    endcase
    push = req_valid_i && req_ready_o;
  end

  // Sequencer: next state, issue pulse, round/result bookkeeping.
  always_comb begin
    state_d       = state_q;
    flush         = 1'b0;
    pop           = 1'b0;
    cin_vld_d     = 1'b0;
    tet_d         = tet_q;
    pos_d         = pos_q;
    round_cnt_d   = round_cnt_q;
    acc_cnt_d     = acc_cnt_q + 5'(push);
    game_fail_d   = game_fail_q;
    final_score_d = final_score_q;
    proto_err_d   = proto_err_q | (core_score_valid_i && (state_q != S_WAIT));
    case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        pop              = 1'b1;
        cin_vld_d        = 1'b1;
        {tet_d, pos_d}   = mem_q[rd_ptr_q];
        state_d          = S_WAIT;
      end
      S_WAIT: begin
        if (core_score_valid_i) begin
          round_cnt_d = round_cnt_q + 4'd1;
          if (core_fail_i) begin
            game_fail_d   = 1'b1;
            final_score_d = core_score_i;
            flush         = 1'b1;
            state_d       = acc_room ? S_DRAIN : S_DONE;
          end else if (({1'b0, round_cnt_q} + 5'd1) == ROUNDS_C) begin
            game_fail_d   = 1'b0;
            final_score_d = core_score_i;
            flush         = 1'b1;
            state_d       = S_DONE;
          end else begin
            state_d = empty ? S_IDLE : S_ISSUE;
          end
        end
`ifdef TETRIS_FEED_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          proto_err_d   = 1'b1;
          game_fail_d   = 1'b1;
          final_score_d = 4'd0;
          flush         = 1'b1;
          state_d       = acc_room ? S_DRAIN : S_DONE;
        end
`endif
      end
      S_DRAIN: begin
        flush = 1'b1;
        if (acc_cnt_q == ROUNDS_C) state_d = S_DONE;
      end
      S_DONE: begin
        flush       = 1'b1;
        acc_cnt_d   = 5'd0;
        round_cnt_d = 4'd0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy; a flush drops contents and any same-cycle push.
  always_comb begin
    wr_en = push && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_cnt_q     <= '0;
      round_cnt_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      cin_vld_q     <= 1'b0;
      tet_q         <= '0;
      pos_q         <= '0;
      game_fail_q   <= 1'b0;
      final_score_q <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_cnt_q     <= acc_cnt_d;
      round_cnt_q   <= round_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      cin_vld_q     <= cin_vld_d;
      tet_q         <= tet_d;
      pos_q         <= pos_d;
      game_fail_q   <= game_fail_d;
      final_score_q <= final_score_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // FIFO storage; occupancy tracking makes stale entries harmless, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {req_tetromino_i, req_position_i};
  end

  assign core_in_valid_o    = cin_vld_q;
  assign core_tetrominoes_o = tet_q;
  assign core_position_o    = pos_q;
  assign game_done_o        = (state_q == S_DONE);
  assign game_fail_o        = game_fail_q;
  assign final_score_o      = final_score_q;
  assign round_cnt_o        = round_cnt_q;
  assign proto_err_o        = proto_err_q;
  assign busy_o             = (state_q != S_IDLE) || !empty;

endmodule
